// File: rtl/datapath_param.sv
// Two-stage ALU datapath with register file, flags, temp carry, forwarding and a program counter.
// Define DPATH_DECIMAL_EN to turn op 8 into a packed-BCD add; otherwise op 8 is a plain ADD.
module datapath_param #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int PC_WIDTH = 16
) (
  input  logic                     ph2,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               op_code,
  input  logic [$clog2(NREGS)-1:0] op_dst,
  input  logic [$clog2(NREGS)-1:0] op_srca,
  input  logic [$clog2(NREGS)-1:0] op_srcb,
  input  logic [WIDTH-1:0]         op_imm,
  input  logic                     op_imm_sel,
  input  logic                     op_wen,
  input  logic                     op_setflags,
  input  logic [1:0]               carry_sel,
  input  logic                     stall,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [3:0]               flags,
  output logic [PC_WIDTH-1:0]      pc,
  input  logic                     pc_inc,
  input  logic                     pc_load,
  input  logic [PC_WIDTH-1:0]      pc_load_val
);

  localparam int IW = $clog2(NREGS);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SHL    = 4'd5;
  localparam logic [3:0] OP_SHR    = 4'd6;
  localparam logic [3:0] OP_PASSB  = 4'd7;
  localparam logic [3:0] OP_DECADD = 4'd8;

  logic [WIDTH-1:0] regs [NREGS];
  logic             tcarry;

  logic             s1_valid;
  logic [3:0]       s1_code;
  logic [IW-1:0]    s1_dst;
  logic             s1_wen;
  logic             s1_setflags;
  logic [1:0]       s1_csel;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_co;
  logic             has_c;
  logic             has_v;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;

  assign op_ready = reset & ~stall;

  // Carry-in is read while the op sits in S1, so it already sees the previous op's commit.
  always_comb begin
    case (s1_csel)
      2'd0:    cin = flags[1];
      2'd1:    cin = 1'b0;
      2'd2:    cin = 1'b1;
      default: cin = tcarry;
    endcase
  end

  assign b_eff = (s1_code == OP_SUB) ? ~s1_b : s1_b;
  assign sum   = {1'b0, s1_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign ovf   = (s1_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);

`ifdef DPATH_DECIMAL_EN
  logic [WIDTH-1:0] dec_res;
  logic             dec_co;
  logic [4:0]       nib;
  logic             dig_c;

  // Digit-serial BCD add; V still reports the binary signed overflow of the same operands.
  always_comb begin
    dec_res = '0;
    dig_c   = cin;
    nib     = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      nib = {1'b0, s1_a[4*i +: 4]} + {1'b0, s1_b[4*i +: 4]} + {4'b0000, dig_c};
      if (nib > 5'd9) begin
        nib   = nib + 5'd6;
        dig_c = 1'b1;
      end else begin
        dig_c = 1'b0;
      end
      dec_res[4*i +: 4] = nib[3:0];
    end
    dec_co = dig_c;
  end
`endif

  always_comb begin
    alu_res = s1_a;
    alu_co  = 1'b0;
    has_c   = 1'b0;
    has_v   = 1'b0;
    case (s1_code)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_co  = sum[WIDTH];
        has_c   = 1'b1;
        has_v   = 1'b1;
      end
      OP_AND:   alu_res = s1_a & s1_b;
      OP_OR:    alu_res = s1_a | s1_b;
      OP_XOR:   alu_res = s1_a ^ s1_b;
      OP_SHL: begin
        alu_res = {s1_a[WIDTH-2:0], cin};
        alu_co  = s1_a[WIDTH-1];
        has_c   = 1'b1;
      end
      OP_SHR: begin
        alu_res = {cin, s1_a[WIDTH-1:1]};
        alu_co  = s1_a[0];
        has_c   = 1'b1;
      end
      OP_PASSB: alu_res = s1_b;
      OP_DECADD: begin
`ifdef DPATH_DECIMAL_EN
        alu_res = dec_res;
        alu_co  = dec_co;
`else
        alu_res = sum[WIDTH-1:0];
        alu_co  = sum[WIDTH];
`endif
        has_c   = 1'b1;
        has_v   = 1'b1;
      end
      default: ;
    endcase
  end

  // The S1 result is written at the same edge the next op latches, so forward it.
  assign opnd_a = (s1_valid && s1_wen && (op_srca == s1_dst)) ? alu_res : regs[op_srca];
  assign opnd_b = op_imm_sel ? op_imm :
                  ((s1_valid && s1_wen && (op_srcb == s1_dst)) ? alu_res : regs[op_srcb]);

  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset) begin
      s1_valid    <= 1'b0;
      s1_code     <= '0;
      s1_dst      <= '0;
      s1_wen      <= 1'b0;
      s1_setflags <= 1'b0;
      s1_csel     <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      flags       <= '0;
      tcarry      <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!stall) begin
      s1_valid <= op_valid;
      if (op_valid) begin
        s1_code     <= op_code;
        s1_dst      <= op_dst;
        s1_wen      <= op_wen;
        s1_setflags <= op_setflags;
        s1_csel     <= carry_sel;
        s1_a        <= opnd_a;
        s1_b        <= opnd_b;
      end
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_data <= alu_res;
        if (s1_wen) regs[s1_dst] <= alu_res;
        if (has_c) tcarry <= alu_co;
        if (s1_setflags)
          flags <= {alu_res[WIDTH-1], (alu_res == '0),
                    (has_c ? alu_co : flags[1]), (has_v ? ovf : flags[0])};
      end
    end
  end

  // The PC runs free of the pipeline stall.
  always_ff @(posedge ph2 or negedge reset) begin
    if (!reset)       pc <= '0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc + 1'b1;
  end

endmodule

// File: tb/tb_datapath_param.sv
// Self-checking bench for datapath_param: directed scenarios plus randomized ops
// checked against a sequential instruction-level model.
module tb_datapath_param;

  localparam int WIDTH    = 8;
  localparam int NREGS    = 4;
  localparam int PC_WIDTH = 16;
  localparam int MOD      = 256;
  localparam int HALF     = 128;
`ifdef DPATH_DECIMAL_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic                ph2 = 1'b0;
  logic                reset = 1'b1;
  logic                op_valid = 1'b0;
  logic                op_ready;
  logic [3:0]          op_code = '0;
  logic [1:0]          op_dst = '0;
  logic [1:0]          op_srca = '0;
  logic [1:0]          op_srcb = '0;
  logic [WIDTH-1:0]    op_imm = '0;
  logic                op_imm_sel = 1'b0;
  logic                op_wen = 1'b0;
  logic                op_setflags = 1'b0;
  logic [1:0]          carry_sel = '0;
  logic                stall = 1'b0;
  logic                res_valid;
  logic [WIDTH-1:0]    res_data;
  logic [3:0]          flags;
  logic [PC_WIDTH-1:0] pc;
  logic                pc_inc = 1'b0;
  logic                pc_load = 1'b0;
  logic [PC_WIDTH-1:0] pc_load_val = '0;

  datapath_param #(.WIDTH(WIDTH), .NREGS(NREGS), .PC_WIDTH(PC_WIDTH)) dut (
    .ph2(ph2), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_dst(op_dst), .op_srca(op_srca), .op_srcb(op_srcb),
    .op_imm(op_imm), .op_imm_sel(op_imm_sel), .op_wen(op_wen), .op_setflags(op_setflags),
    .carry_sel(carry_sel), .stall(stall), .res_valid(res_valid), .res_data(res_data),
    .flags(flags), .pc(pc), .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val)
  );

  always #5 ph2 = ~ph2;

  int checkCount = 0;
  int failCount  = 0;

  // Architectural model: ops execute in program order at acceptance time.
  logic [WIDTH-1:0] mRegs [NREGS];
  logic [3:0]       mFlags;
  logic [3:0]       cFlags;
  logic             mTc;
  logic [15:0]      mPc;
  logic             p0Valid, p1Valid;
  logic [7:0]       p0Data, p1Data;
  logic [3:0]       p0Flags, p1Flags;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  task automatic modelAlu(input int code, input int a, input int b, input int cin,
                          output int res, output int co, output bit hasC, output bit hasV, output bit v);
    int s, sv, c, x;
    res = a; co = 0; hasC = 0; hasV = 0; v = 0;
    if (code == 0 || (code == 8 && !DEC_EN)) begin
      s = a + b + cin; res = s % MOD; co = (s >= MOD) ? 1 : 0;
      sv = sgn(a) + sgn(b) + cin; v = (sv >= HALF) || (sv < -HALF); hasC = 1; hasV = 1;
    end else if (code == 1) begin
      s = a + (MOD - 1 - b) + cin; res = s % MOD; co = (s >= MOD) ? 1 : 0;
      sv = sgn(a) - sgn(b) - 1 + cin; v = (sv >= HALF) || (sv < -HALF); hasC = 1; hasV = 1;
    end else if (code == 8) begin
      c = cin; res = 0;
      for (int d = 0; d < WIDTH / 4; d++) begin
        x = ((a >> (4 * d)) % 16) + ((b >> (4 * d)) % 16) + c;
        if (x > 9) begin x = (x + 6) % 16; c = 1; end else c = 0;
        res = res + (x << (4 * d));
      end
      co = c; sv = sgn(a) + sgn(b) + cin; v = (sv >= HALF) || (sv < -HALF); hasC = 1; hasV = 1;
    end else begin
      case (code)
        2: res = a & b;
        3: res = a | b;
        4: res = a ^ b;
        5: begin res = (a * 2 + cin) % MOD; co = (a >= HALF) ? 1 : 0; hasC = 1; end
        6: begin res = a / 2 + cin * HALF; co = a % 2; hasC = 1; end
        7: res = b;
        default: res = a;
      endcase
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
    mFlags = '0; cFlags = '0; mTc = 1'b0; mPc = '0;
    p0Valid = 1'b0; p1Valid = 1'b0; p0Data = '0; p1Data = '0; p0Flags = '0; p1Flags = '0;
  endtask

  // One rising edge: advance the model, then compare all outputs 1 time unit later.
  task automatic stepCycle();
    int a, b, cin, res, co;
    bit hasC, hasV, v;
    @(posedge ph2);
    if (reset) begin
      if (pc_load) mPc = pc_load_val;
      else if (pc_inc) mPc = mPc + 16'd1;
      if (!stall) begin
        p1Valid = p0Valid; p1Data = p0Data; p1Flags = p0Flags;
        if (p1Valid) cFlags = p1Flags;
        p0Valid = op_valid;
        if (op_valid) begin
          a = int'(mRegs[op_srca]);
          b = op_imm_sel ? int'(op_imm) : int'(mRegs[op_srcb]);
          case (carry_sel)
            2'd0: cin = int'(mFlags[1]);
            2'd1: cin = 0;
            2'd2: cin = 1;
            default: cin = int'(mTc);
          endcase
          modelAlu(int'(op_code), a, b, cin, res, co, hasC, hasV, v);
          if (op_wen) mRegs[op_dst] = 8'(res);
          if (hasC) mTc = co[0];
          if (op_setflags)
            mFlags = {res >= HALF, res == 0, (hasC ? co[0] : mFlags[1]), (hasV ? v : mFlags[0])};
          p0Data = 8'(res); p0Flags = mFlags;
        end
      end
    end
    #1;
    checkOutput("res_valid", 32'(res_valid), 32'(p1Valid));
    if (p1Valid) checkOutput("res_data", 32'(res_data), 32'(p1Data));
    checkOutput("flags", 32'(flags), 32'(cFlags));
    checkOutput("pc", 32'(pc), 32'(mPc));
    checkOutput("op_ready", 32'(op_ready), 32'(!stall));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] code, input int dst, input int sa,
                               input int sb, input logic [7:0] imm, input logic isel, input logic wen,
                               input logic setf, input logic [1:0] csel, input logic stl);
    op_valid = v; op_code = code; op_dst = 2'(dst); op_srca = 2'(sa); op_srcb = 2'(sb);
    op_imm = imm; op_imm_sel = isel; op_wen = wen; op_setflags = setf; carry_sel = csel; stall = stl;
    stepCycle();
  endtask

  task automatic bubble();
    applyStimulus(1'b0, 4'd0, 0, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #2;
    clearModel();
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_op_ready", 32'(op_ready), 32'd0);
    @(negedge ph2);
    reset = 1'b1;
  endtask

  initial begin
    clearModel();
    #1;
    doReset();

    // Signed overflow into the sign bit
    applyStimulus(1'b1, 4'd0, 1, 0, 0, 8'h7F, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd0, 2, 1, 0, 8'h01, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0);
    bubble();
    checkOutput("ovf_res", 32'(res_data), 32'h80);
    checkOutput("ovf_flags", 32'(flags), 32'b1001);

    // Back-to-back dependency through forwarding
    applyStimulus(1'b1, 4'd0, 1, 0, 0, 8'h05, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd4, 2, 1, 0, 8'h0F, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    checkOutput("fwd_first", 32'(res_data), 32'h05);
    bubble();
    checkOutput("fwd_res", 32'(res_data), 32'h0A);
    checkOutput("fwd_valid", 32'(res_valid), 32'd1);

    // Two-word add chained through the temp carry
    applyStimulus(1'b1, 4'd0, 3, 0, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd0, 3, 3, 0, 8'h01, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd0, 2, 0, 0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
    checkOutput("chain_low", 32'(res_data), 32'h00);
    bubble();
    checkOutput("chain_high", 32'(res_data), 32'h01);
    checkOutput("chain_flags", 32'(flags), 32'b1001);

    // Stall with an op in S1, while another op is offered and must be ignored
    applyStimulus(1'b1, 4'd7, 1, 0, 0, 8'h11, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd7, 3, 0, 0, 8'h3C, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd7, 0, 0, 0, 8'h77, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1);
      checkOutput("stall_res", 32'(res_data), 32'h11);
      checkOutput("stall_flags", 32'(flags), 32'b1001);
      checkOutput("stall_ready", 32'(op_ready), 32'd0);
    end
    bubble();
    checkOutput("unstall_res", 32'(res_data), 32'h3C);
    checkOutput("unstall_flags", 32'(flags), 32'b0001);
    applyStimulus(1'b1, 4'd9, 2, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    bubble();
    checkOutput("stall_nowrite", 32'(res_data), 32'h00);

    // PC wrap and load priority
    pc_load = 1'b1; pc_load_val = 16'hFFFF;
    bubble();
    pc_load = 1'b0; pc_inc = 1'b1;
    bubble();
    checkOutput("pc_wrap", 32'(pc), 32'h0000);
    pc_load = 1'b1; pc_load_val = 16'h1234;
    bubble();
    checkOutput("pc_load_prio", 32'(pc), 32'h1234);
    pc_load = 1'b0; pc_inc = 1'b0;

    // Op 8: decimal add when enabled, binary add otherwise
    applyStimulus(1'b1, 4'd7, 1, 0, 0, 8'h45, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd8, 2, 1, 0, 8'h38, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    bubble();
    checkOutput("decadd_45_38", 32'(res_data), DEC_EN ? 32'h83 : 32'h7D);
    checkOutput("decadd_45_38_c", 32'(flags[1]), 32'd0);
    applyStimulus(1'b1, 4'd7, 1, 0, 0, 8'h99, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
    applyStimulus(1'b1, 4'd8, 2, 1, 0, 8'h01, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
    bubble();
    checkOutput("decadd_99_01", 32'(res_data), DEC_EN ? 32'h00 : 32'h9A);
    checkOutput("decadd_99_01_c", 32'(flags[1]), DEC_EN ? 32'd1 : 32'd0);

    // Randomized traffic with a reset dropped into the middle of it
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      pc_inc = 1'($urandom_range(0, 1));
      pc_load = ($urandom_range(0, 7) == 0);
      pc_load_val = 16'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/datapath_param.md
DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 SHALL take parameters WIDTH (default 8, data width, multiple of 4, >=8), NREGS (default 4, register count, power of 2, >=2), and PC_WIDTH (default 16, program counter width, >=WIDTH).
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-low. Ports:
- ph2  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low.
- op_valid  in  1  op offered.
- op_ready  out  1  op accepted when op_valid && op_ready.
- op_code  in  4  ALU operation.
- op_dst, op_srca, op_srcb  in  log2(NREGS)  register indices.
- op_imm  in  WIDTH  immediate value.
- op_imm_sel  in  1  B operand = op_imm.
- op_wen  in  1  write result to op_dst.
- op_setflags  in  1  update flags.
- carry_sel  in  2  carry-in select: 0 = flag C, 1 = 0, 2 = 1, 3 = temp carry.
- stall  in  1  pipeline hold.
- res_valid  out  1  result valid.
- res_data  out  WIDTH  result.
- flags  out  4  architectural {N,Z,C,V}.
- pc  out  PC_WIDTH  program counter.
- pc_inc  in  1  increment pc.
- pc_load  in  1  load pc.
- pc_load_val  in  PC_WIDTH  pc load value.

Function
REQ-003 SHALL have a two-stage pipeline: S1 holds the latched op and operands, and S2 holds the result.
REQ-004 SHALL drive op_ready = !stall.
REQ-005 SHALL latch an accepted op into S1 at edge k, compute the ALU result from S1 combinationally, and capture it into S2 at edge k+1; res_valid SHALL be high for the cycle following edge k+1 (latency 2 edges).
REQ-006 SHALL, at the S1->S2 transfer, write the register file when op_wen is set and update flags when op_setflags is set; both SHALL be visible to an op latched at that same edge.
REQ-007 SHALL forward the S1 ALU result to operand reads when S1 is valid, S1 op_wen=1, and the source index equals the S1 op_dst; with no such match, operands SHALL come from the register file.
REQ-008 SHALL, while stall=1, hold S1, S2, the register file, flags, temp carry and res_valid unchanged; no write or flag update SHALL occur.
REQ-009 SHALL, with stall=0 and no op accepted, move a bubble into S1; res_valid SHALL drop after the bubble reaches S2.
REQ-010 SHALL implement these op_code values (C = carry-in):
- 0 ADD: A+B+C.
- 1 SUB: A+~B+C.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SHL: C into LSB, MSB out to carry.
- 6 SHR: C into MSB, LSB out to carry.
- 7 PASSB.
- 8 DECADD (see REQ-017).
- 9-15 PASSA.
REQ-011 SHALL compute N = result MSB and Z = (result == 0); C = carry-out for ops 0, 1, 5, 6, 8; V = signed overflow for ops 0, 1, 8. C and V SHALL be preserved for other ops.
REQ-012 SHALL load the temp carry from every S1->S2 carry-out regardless of op_setflags; carry_sel=3 SHALL use it, enabling multi-word chains without touching the architectural flags.
REQ-013 SHALL wrap all arithmetic modulo 2^WIDTH.
REQ-014 SHALL update the PC every non-reset edge, independent of stall: pc_load takes priority over pc_inc; pc_inc increments modulo 2^PC_WIDTH (all-ones -> 0); with neither asserted, pc holds.

Reset
REQ-015 SHALL, while reset=0, asynchronously clear S1/S2 valid, res_data, all registers, flags, temp carry and pc to 0; op_ready SHALL be 0 during reset.
REQ-016 SHALL discard in-flight ops on reset assertion mid-operation; no write from them SHALL occur after reset releases.

Configuration
REQ-017 SHALL, with DPATH_DECIMAL_EN defined, execute op 8 as packed-BCD add: per-nibble +6 adjust when a nibble exceeds 9 or produces a nibble carry, with C = carry-out of the top digit. Without DPATH_DECIMAL_EN, op 8 SHALL behave identically to op 0 ADD and no decimal logic SHALL be synthesised.

Verification
REQ-018 SHALL cover: after reset, op ADD r1=r0+imm 0x7F with C=0, then ADD r2=r1+imm 0x01, setflags -> res_data 0x80 with N=1, V=1, C=0, Z=0.
REQ-019 SHALL cover: back-to-back dependency, r1 = 0x05 then r2 = r1 XOR imm 0x0F on consecutive cycles -> r2 = 0x0A via forwarding, with no bubble.
REQ-020 SHALL cover: 16-bit add as two ops, low byte 0xFF+0x01 with carry_sel=1 and setflags=0, then high byte 0x00+0x00 with carry_sel=3 -> low 0x00, high 0x01, flags unchanged.
REQ-021 SHALL cover: stall=1 for 3 cycles with an op in S1 -> res_data, registers and flags frozen and op_ready=0; the result appears one edge after stall drops.
REQ-022 SHALL cover: pc = 0xFFFF with pc_inc -> 0x0000; pc_load and pc_inc together with pc_load_val=0x1234 -> 0x1234.
REQ-023 SHALL cover: with DPATH_DECIMAL_EN, DECADD 0x45+0x38 with C=0 -> 0x83, C=0, and DECADD 0x99+0x01 -> 0x00, C=1; without the macro, DECADD 0x45+0x38 -> 0x7D.
